// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data load/store.
// Data wins by default; a starvation counter forces a fetch grant.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  // A requester in its hit cycle is still holding the old request.
  assign i_req = iREN & ~ihit_q;
  assign d_req = (dREN | dWEN) & ~dhit_q;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && (starve_q == LIMIT)) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    starve_d = starve_q;
    ihit_d   = 1'b0;
    dhit_d   = 1'b0;
    iload_d  = iload_q;
    dload_d  = dload_q;
    addr_d   = addr_q;
    store_d  = store_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = IACC;
          addr_d   = iaddr;
          starve_d = '0;
        end else if (grant_d) begin
          state_d = DACC;
          addr_d  = daddr;
          wr_d    = dWEN;
          store_d = dstore;
          if (!iREN) begin
            starve_d = '0;
          end else if (starve_q != LIMIT) begin
            starve_d = starve_q + CW'(1);
          end
        end
      end
      IACC: begin
        if (ram_ready) begin
          state_d = IDLE;
          ihit_d  = 1'b1;
          iload_d = ramload;
        end
      end
      DACC: begin
        if (ram_ready) begin
          state_d = IDLE;
          dhit_d  = 1'b1;
          if (!wr_q) begin
            dload_d = ramload;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      starve_q <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
      addr_q   <= '0;
      store_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      starve_q <= starve_d;
      ihit_q   <= ihit_d;
      dhit_q   <= dhit_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
    end
  end

  // Enables decode straight from state so reset drops them at once.
  assign ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
  assign ramWEN   = (state_q == DACC) & wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed-vector bench for memory_arbiter.
// Inputs change on the falling edge; outputs are checked there too.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  memory_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .dhit     (dhit),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int n_ih  = 0;
  int n_dh  = 0;
  int n_acc = 0;
  logic prev_acc = 1'b0;

  // Pulse and access-start counters, sampled just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (ihit) n_ih++;
    if (dhit) n_dh++;
    if ((ramREN | ramWEN) && !prev_acc) n_acc++;
    prev_acc = ramREN | ramWEN;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ren"},   32'(ramREN),  0);
    chk({tag, "_wen"},   32'(ramWEN),  0);
    chk({tag, "_ihit"},  32'(ihit),    0);
    chk({tag, "_dhit"},  32'(dhit),    0);
    chk({tag, "_iload"}, iload,        0);
    chk({tag, "_dload"}, dload,        0);
    chk({tag, "_addr"},  ramaddr,      0);
    chk({tag, "_store"}, ramstore,     0);
  endtask

  int i0, d0, a0, ng;
  logic [5:0] is_i;

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    #3;
    chk_zero("rst");
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // ram_ready while idle has no effect
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0;
    step();
    chk("idle_rdy", 32'({ihit, dhit, ramREN, ramWEN}), 0);

    // single fetch, RAM ready two cycles after ramREN
    i0 = n_ih; d0 = n_dh; a0 = n_acc;
    iREN = 1'b1; iaddr = 32'h40;
    step();
    chk("t2_ren",  32'(ramREN), 1);
    chk("t2_wen",  32'(ramWEN), 0);
    chk("t2_addr", ramaddr, 32'h40);
    step();
    chk("t2_wait", 32'({ramREN, ihit}), 32'b10);
    step();
    ram_ready = 1'b1; ramload = 32'hDEADBEEF;
    step();
    ram_ready = 1'b0; ramload = '0;
    chk("t2_ihit",  32'(ihit), 1);
    chk("t2_iload", iload, 32'hDEADBEEF);
    chk("t2_idle",  32'(ramREN), 0);
    iREN = 1'b0;
    step();
    chk("t2_pulse", 32'(ihit), 0);
    chk("t2_hold",  iload, 32'hDEADBEEF);
    step(); step();
    chk("t2_nih",  32'(n_ih - i0), 1);
    chk("t2_ndh",  32'(n_dh - d0), 0);
    chk("t2_nacc", 32'(n_acc - a0), 1);

    // simultaneous fetch and store: store goes first
    i0 = n_ih; d0 = n_dh;
    iREN = 1'b1; iaddr = 32'h40;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
    step();
    chk("t3_wen",   32'({ramWEN, ramREN}), 32'b10);
    chk("t3_addr",  ramaddr, 32'h100);
    chk("t3_store", ramstore, 32'h1234);
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0;
    chk("t3_dhit",  32'(dhit), 1);
    chk("t3_dload", dload, 0);
    dWEN = 1'b0;
    step();
    chk("t3_iren",  32'({ramREN, ramWEN}), 32'b10);
    chk("t3_iaddr", ramaddr, 32'h40);
    ram_ready = 1'b1; ramload = 32'hCAFEF00D;
    step();
    ram_ready = 1'b0;
    chk("t3_ihit",  32'(ihit), 1);
    chk("t3_iload", iload, 32'hCAFEF00D);
    iREN = 1'b0;
    step(); step();
    chk("t3_nih", 32'(n_ih - i0), 1);
    chk("t3_ndh", 32'(n_dh - d0), 1);

    // starvation: fetch withheld only in dhit cycles, one-cycle RAM
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h40;
    ng = 0; is_i = '0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      step();
      if (ramREN | ramWEN) begin
        is_i[ng] = (ramaddr == 32'h40);
        if (ng == 3) chk("t4_sat", 32'(dut.starve_q), 4);
        if (ng == 4) chk("t4_clr", 32'(dut.starve_q), 0);
        ng++;
        ram_ready = 1'b1;
        ramload = 32'(c + 1);
      end else begin
        ram_ready = 1'b0;
      end
      iREN = !dhit;
    end
    dREN = 1'b0; iREN = 1'b0;
    chk("t4_ngrant", 32'(ng), 6);
    chk("t4_order",  32'(is_i), 32'b010000);
    step();
    ram_ready = 1'b0;
    step(); step();

    // reset while a load waits on the RAM
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h200;
    step();
    chk("t5_ren", 32'(ramREN), 1);
    step();
    #2 nRST = 1'b0;
    #1;
    chk("t5_drop", 32'({ramREN, ramWEN}), 0);
    chk("t5_addr", ramaddr, 0);
    chk("t5_dld",  dload, 0);
    @(negedge CLK);
    chk("t5_nodhit", 32'(dhit), 0);
    d0 = n_dh;
    nRST = 1'b1;
    step();
    chk("t5_regrant", 32'(ramREN), 1);
    chk("t5_raddr",   ramaddr, 32'h200);
    ram_ready = 1'b1; ramload = 32'h55AA;
    step();
    ram_ready = 1'b0;
    chk("t5_dhit",  32'(dhit), 1);
    chk("t5_dload", dload, 32'h55AA);
    dREN = 1'b0;
    step(); step();
    chk("t5_ndh", 32'(n_dh - d0), 1);

    // read and write together count as a write
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hABCD;
    step();
    chk("t6_rw",    32'({ramWEN, ramREN}), 32'b10);
    chk("t6_store", ramstore, 32'hABCD);
    ram_ready = 1'b1; ramload = 32'h9999;
    step();
    ram_ready = 1'b0;
    chk("t6_dhit",  32'(dhit), 1);
    chk("t6_dload", dload, 32'h55AA);
    dREN = 1'b0; dWEN = 1'b0;
    step();

    // asynchronous reset in the middle of a fetch
    iREN = 1'b1; iaddr = 32'h80;
    step();
    chk("t1_ren", 32'(ramREN), 1);
    #2 nRST = 1'b0;
    #1;
    chk_zero("t1");
    iREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
